// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush scheduler for a 5-stage RV32I pipeline.
// Latency: stall_o/flush_o/imem_req_o are combinational (same-cycle hazard response); counters are registered.
// Backpressure: an I-mem or D-mem wait holds the upstream stages and inserts bubbles downstream.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   id_r1_i/id_r2_i/id_use_r*_i   source registers read by the instruction in ID
//   ex_rd_i/ex_mem_re_i           destination register and load flag of the instruction in EX
//   ex_taken_i                    EX resolved a taken branch/jump this cycle
//   mem_re_i/mem_wr_i             MEM-stage D-mem access active
//   dmem_ready_i                  D-mem completes the MEM access this cycle
//   imem_req_o/imem_ready_i       fetch request for the current PC and its completion
//   stall_o/flush_o               per-stage hold / bubble (0=PC,1=IF/ID,2=ID/EX,3=EX/MEM,4=MEM/WB)
//   stall_cnt_o/flush_cnt_o       saturating counts of PC-stall cycles and redirects
module pipe_hazard_ctrl #(
   parameter int STAGES = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        id_r1_i,
   input  logic [4:0]        id_r2_i,
   input  logic              id_use_r1_i,
   input  logic              id_use_r2_i,
   input  logic [4:0]        ex_rd_i,
   input  logic              ex_mem_re_i,
   input  logic              ex_taken_i,
   input  logic              mem_re_i,
   input  logic              mem_wr_i,
   input  logic              dmem_ready_i,
   output logic              imem_req_o,
   input  logic              imem_ready_i,
   output logic [STAGES-1:0] stall_o,
   output logic [STAGES-1:0] flush_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o
);

   typedef enum logic {ST_RUN, ST_DWAIT} st_e;

   st_e              st_q, st_d;
   logic             drop_pend_q, drop_pend_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic dmem_wait;
   logic load_use;
   logic imem_wait;
   logic drop_hit;

   // The fetch request is held continuously; stalls only freeze the PC it points at.
   assign imem_req_o = ~rst;

   assign dmem_wait = (mem_re_i | mem_wr_i) & ~dmem_ready_i;
   // x0 is hard-wired to zero, so a load targeting it can never create a dependency.
   assign load_use  = ex_mem_re_i & (ex_rd_i != 5'd0) &
                      ((id_use_r1_i & (ex_rd_i == id_r1_i)) |
                       (id_use_r2_i & (ex_rd_i == id_r2_i)));
   assign imem_wait = imem_req_o & ~imem_ready_i;
   assign drop_hit  = drop_pend_q & imem_ready_i;

   always_comb begin
      stall_o     = '0;
      flush_o     = '0;
      st_d        = st_q;
      drop_pend_d = drop_pend_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;

      if (!rst) begin
         if (dmem_wait) begin
            // EX is frozen too, so a pending redirect stays asserted and is serviced later.
            stall_o[3:0] = 4'b1111;
            flush_o[4]   = 1'b1;
         end else if (ex_taken_i) begin
            flush_o[1] = 1'b1;
            flush_o[2] = 1'b1;
            if (~&flush_cnt_q) flush_cnt_d = flush_cnt_q + CNT_W'(1);
            // The in-flight fetch belongs to the wrong path; its response must be discarded.
            if (imem_wait) drop_pend_d = 1'b1;
         end else if (load_use) begin
            // The load leaves EX next cycle, so a single bubble resolves the hazard.
            stall_o[1:0] = 2'b11;
            flush_o[2]   = 1'b1;
         end else if (imem_wait) begin
            stall_o[0] = 1'b1;
            flush_o[1] = 1'b1;
         end else if (drop_hit) begin
            // Stale response: bubble it and re-fetch the (already redirected) PC.
            stall_o[0]  = 1'b1;
            flush_o[1]  = 1'b1;
            drop_pend_d = 1'b0;
         end

         if (stall_o[0] && (~&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);

         case (st_q)
            ST_RUN:   if (dmem_wait)  st_d = ST_DWAIT;
            ST_DWAIT: if (!dmem_wait) st_d = ST_RUN;
            default:                  st_d = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q        <= ST_RUN;
         drop_pend_q <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         st_q        <= st_d;
         drop_pend_q <= drop_pend_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios, a per-cycle reference model
// and hand-computed literal checks at key points.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_r1, id_r2, ex_rd;
   logic        id_use_r1, id_use_r2, ex_mem_re, ex_taken;
   logic        mem_re, mem_wr, dmem_ready, imem_ready;
   logic        imem_req;
   logic [4:0]  stall, flush;
   logic [31:0] stall_cnt, flush_cnt;

   int vecs = 0;
   int miss = 0;

   pipe_hazard_ctrl #(.STAGES(5), .CNT_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .id_r1_i      (id_r1),
      .id_r2_i      (id_r2),
      .id_use_r1_i  (id_use_r1),
      .id_use_r2_i  (id_use_r2),
      .ex_rd_i      (ex_rd),
      .ex_mem_re_i  (ex_mem_re),
      .ex_taken_i   (ex_taken),
      .mem_re_i     (mem_re),
      .mem_wr_i     (mem_wr),
      .dmem_ready_i (dmem_ready),
      .imem_req_o   (imem_req),
      .imem_ready_i (imem_ready),
      .stall_o      (stall),
      .flush_o      (flush),
      .stall_cnt_o  (stall_cnt),
      .flush_cnt_o  (flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Hazard class -> output pattern table (class 0 = no hazard).
   logic [4:0] tbl_stall [6];
   logic [4:0] tbl_flush [6];
   initial begin
      tbl_stall[0] = 5'b00000; tbl_flush[0] = 5'b00000;
      tbl_stall[1] = 5'b01111; tbl_flush[1] = 5'b10000; // D-mem wait
      tbl_stall[2] = 5'b00000; tbl_flush[2] = 5'b00110; // redirect
      tbl_stall[3] = 5'b00011; tbl_flush[3] = 5'b00100; // load-use
      tbl_stall[4] = 5'b00001; tbl_flush[4] = 5'b00010; // I-mem wait
      tbl_stall[5] = 5'b00001; tbl_flush[5] = 5'b00010; // stale drop
   end

   bit     m_drop = 1'b0;
   longint m_sc   = 0;
   longint m_fc   = 0;
   localparam longint MAXC = 64'h0000_0000_FFFF_FFFF;

   always @(negedge clk) begin
      int cls;
      bit lu;
      if (rst) begin
         chk("m_stall", {59'd0, stall}, 64'd0);
         chk("m_flush", {59'd0, flush}, 64'd0);
         chk("m_ireq", {63'd0, imem_req}, 64'd0);
         chk("m_scnt", {32'd0, stall_cnt}, m_sc);
         chk("m_fcnt", {32'd0, flush_cnt}, m_fc);
         m_drop = 1'b0;
         m_sc   = 0;
         m_fc   = 0;
      end else begin
         lu = ex_mem_re && ex_rd != 0 &&
              ((id_use_r1 && ex_rd == id_r1) || (id_use_r2 && ex_rd == id_r2));
         if ((mem_re || mem_wr) && !dmem_ready) cls = 1;
         else if (ex_taken)                     cls = 2;
         else if (lu)                           cls = 3;
         else if (!imem_ready)                  cls = 4;
         else if (m_drop)                       cls = 5;
         else                                   cls = 0;
         chk("m_stall", {59'd0, stall}, {59'd0, tbl_stall[cls]});
         chk("m_flush", {59'd0, flush}, {59'd0, tbl_flush[cls]});
         chk("m_ireq", {63'd0, imem_req}, 64'd1);
         chk("m_scnt", {32'd0, stall_cnt}, m_sc);
         chk("m_fcnt", {32'd0, flush_cnt}, m_fc);
         if (cls == 2) begin
            if (m_fc < MAXC) m_fc++;
            if (!imem_ready) m_drop = 1'b1;
         end
         if (cls == 5) m_drop = 1'b0;
         if (tbl_stall[cls][0] && m_sc < MAXC) m_sc++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      id_r1 = 5'd0; id_r2 = 5'd0; id_use_r1 = 1'b0; id_use_r2 = 1'b0;
      ex_rd = 5'd0; ex_mem_re = 1'b0; ex_taken = 1'b0;
      mem_re = 1'b0; mem_wr = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      adv();
      adv();
      rst = 1'b0;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      adv();
      mid();
      chk("rst_stall", {59'd0, stall}, 64'd0);
      chk("rst_ireq", {63'd0, imem_req}, 64'd0);
      adv();
      chk("rst_scnt", {32'd0, stall_cnt}, 64'd0);
      rst = 1'b0;
      adv();

      // Load-use on rs2: one bubble, then clear.
      ex_mem_re = 1'b1; ex_rd = 5'd5; id_r2 = 5'd5; id_use_r2 = 1'b1;
      id_r1 = 5'd3; id_use_r1 = 1'b1;
      mid();
      chk("lu_stall", {59'd0, stall}, 64'b00011);
      chk("lu_flush", {59'd0, flush}, 64'b00100);
      adv();
      ex_mem_re = 1'b0;
      mid();
      chk("lu_after_stall", {59'd0, stall}, 64'd0);
      chk("lu_after_flush", {59'd0, flush}, 64'd0);
      chk("lu_scnt", {32'd0, stall_cnt}, 64'd1);
      adv();

      // Load to x0 never stalls.
      idle();
      ex_mem_re = 1'b1; ex_rd = 5'd0; id_r1 = 5'd0; id_use_r1 = 1'b1;
      mid();
      chk("x0_stall", {59'd0, stall}, 64'd0);
      chk("x0_flush", {59'd0, flush}, 64'd0);
      adv();

      // Load-use via rs1; matching rs2 without its use flag does not count.
      idle();
      ex_mem_re = 1'b1; ex_rd = 5'd7; id_r1 = 5'd7; id_use_r1 = 1'b1;
      mid();
      chk("lu_r1_stall", {59'd0, stall}, 64'b00011);
      adv();
      idle();
      ex_mem_re = 1'b1; ex_rd = 5'd7; id_r2 = 5'd7; id_use_r2 = 1'b0; id_r1 = 5'd1; id_use_r1 = 1'b1;
      mid();
      chk("nouse_stall", {59'd0, stall}, 64'd0);
      adv();

      // Redirect beats load-use.
      idle();
      ex_taken = 1'b1; ex_mem_re = 1'b1; ex_rd = 5'd9; id_r1 = 5'd9; id_use_r1 = 1'b1;
      mid();
      chk("br_lu_flush", {59'd0, flush}, 64'b00110);
      chk("br_lu_stall", {59'd0, stall}, 64'd0);
      adv();
      idle();
      mid();
      chk("br_lu_fcnt", {32'd0, flush_cnt}, 64'd1);
      adv();

      // D-mem wait with a pending redirect held in EX for 3 cycles.
      do_reset();
      mem_re = 1'b1; dmem_ready = 1'b0; ex_taken = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mid();
         chk("dw_stall", {59'd0, stall}, 64'b01111);
         chk("dw_flush", {59'd0, flush}, 64'b10000);
         adv();
      end
      dmem_ready = 1'b1;
      mid();
      chk("dw_done_flush", {59'd0, flush}, 64'b00110);
      chk("dw_done_stall", {59'd0, stall}, 64'd0);
      adv();
      idle();
      mid();
      chk("dw_fcnt", {32'd0, flush_cnt}, 64'd1);
      chk("dw_scnt", {32'd0, stall_cnt}, 64'd3);
      adv();

      // Redirect while a fetch is outstanding: stale response dropped once.
      imem_ready = 1'b0; ex_taken = 1'b1;
      mid();
      chk("drop_br_flush", {59'd0, flush}, 64'b00110);
      chk("drop_br_stall", {59'd0, stall}, 64'd0);
      adv();
      ex_taken = 1'b0;
      mid();
      chk("drop_iw_stall", {59'd0, stall}, 64'b00001);
      chk("drop_iw_flush", {59'd0, flush}, 64'b00010);
      adv();
      imem_ready = 1'b1;
      mid();
      chk("drop_stall", {59'd0, stall}, 64'b00001);
      chk("drop_flush", {59'd0, flush}, 64'b00010);
      adv();
      mid();
      chk("drop_clr_stall", {59'd0, stall}, 64'd0);
      chk("drop_clr_flush", {59'd0, flush}, 64'd0);
      adv();

      // Double redirect, then drop survives a D-mem wait.
      imem_ready = 1'b0; ex_taken = 1'b1;
      adv();
      adv();
      ex_taken = 1'b0; imem_ready = 1'b1; mem_wr = 1'b1; dmem_ready = 1'b0;
      mid();
      chk("surv_dw_stall", {59'd0, stall}, 64'b01111);
      adv();
      dmem_ready = 1'b1;
      mid();
      chk("surv_drop_stall", {59'd0, stall}, 64'b00001);
      chk("surv_drop_flush", {59'd0, flush}, 64'b00010);
      adv();
      idle();
      mid();
      chk("surv_once_flush", {59'd0, flush}, 64'd0);
      adv();

      // Reset during D-mem wait with a drop pending.
      imem_ready = 1'b0; ex_taken = 1'b1;
      adv();
      ex_taken = 1'b0; imem_ready = 1'b1; mem_re = 1'b1; dmem_ready = 1'b0;
      adv();
      rst = 1'b1;
      mid();
      chk("rstdw_stall", {59'd0, stall}, 64'd0);
      chk("rstdw_flush", {59'd0, flush}, 64'd0);
      chk("rstdw_ireq", {63'd0, imem_req}, 64'd0);
      adv();
      mid();
      chk("rstdw_scnt", {32'd0, stall_cnt}, 64'd0);
      chk("rstdw_fcnt", {32'd0, flush_cnt}, 64'd0);
      adv();
      rst = 1'b0;
      idle();
      mid();
      chk("post_rst_stall", {59'd0, stall}, 64'd0);
      chk("post_rst_flush", {59'd0, flush}, 64'd0);
      chk("post_rst_ireq", {63'd0, imem_req}, 64'd1);
      adv();
      adv();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage RV32I pipeline.
- Drives the per-stage stall and flush buses consumed by the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves four hazard classes: load-use, taken branch/jump redirect, I-mem wait and D-mem wait.
- Also tracks stale instruction-fetch responses after a redirect and keeps stall/flush event counters.

Parameters:
- STAGES, 5, width of stall/flush buses. Bit mapping: 0 = PC, 1 = IF/ID, 2 = ID/EX, 3 = EX/MEM, 4 = MEM/WB.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- id_r1_i  in  5  rs1 address of the instruction in ID.
- id_r2_i  in  5  rs2 address of the instruction in ID.
- id_use_r1_i  in  1  ID instruction reads rs1.
- id_use_r2_i  in  1  ID instruction reads rs2.
- ex_rd_i  in  5  rd of the instruction in EX.
- ex_mem_re_i  in  1  EX instruction is a load.
- ex_taken_i  in  1  EX resolved a taken branch or jump (PC target valid this cycle).
- mem_re_i  in  1  MEM-stage load request active.
- mem_wr_i  in  1  MEM-stage store request active.
- dmem_ready_i  in  1  D-mem completes the MEM-stage access this cycle.
- imem_req_o  out  1  fetch request for current PC.
- imem_ready_i  in  1  I-mem returns the instruction for the outstanding request.
- stall_o  out  STAGES  per-stage hold.
- flush_o  out  STAGES  per-stage bubble insert.
- stall_cnt_o  out  CNT_W  cycles with stall_o[0]=1.
- flush_cnt_o  out  CNT_W  number of redirects taken.

Behaviour:
- State register `st`: RUN, DWAIT. Separate flag `drop_pend` (1 bit).
- stall_o and flush_o are combinational from inputs and state (same-cycle hazard response). Counters are registered.
- Reset (rst=1 at clk edge):
  - st=RUN, drop_pend=0, both counters=0.
  - While rst is high: stall_o=0, flush_o=0, imem_req_o=0.
- Priority per cycle, highest first:
  - P1 D-mem wait: (mem_re_i|mem_wr_i) & !dmem_ready_i.
    - stall_o[3:0]=1111, flush_o[4]=1, others 0.
    - st<=DWAIT.
    - ex_taken_i and load-use are ignored: EX is frozen, so ex_taken_i remains asserted and is serviced afterwards.
  - P2 redirect: ex_taken_i.
    - flush_o[1]=1, flush_o[2]=1, stall_o=0; PC loads target.
    - flush_cnt_o+1 (saturates at all-ones).
    - If a fetch is outstanding (imem_req_o=1 and imem_ready_i=0), set drop_pend<=1.
  - P3 load-use: ex_mem_re_i & ex_rd_i!=0 & ((id_use_r1_i & ex_rd_i==id_r1_i) | (id_use_r2_i & ex_rd_i==id_r2_i)).
    - stall_o[1:0]=11, flush_o[2]=1.
    - Exactly one bubble per load.
  - P4 I-mem wait: imem_req_o & !imem_ready_i.
    - stall_o[0]=1, flush_o[1]=1.
    - IF/ID receives a bubble, so ID/EX onward continues draining.
  - P5 drop: drop_pend & imem_ready_i.
    - flush_o[1]=1 (stale instruction discarded), stall_o[0]=1 (re-fetch same PC).
    - drop_pend<=0.
- imem_req_o=1 whenever not in reset. It is held while waiting and is not dropped by stalls.
- DWAIT→RUN on the cycle dmem_ready_i=1. In that cycle P1 does not apply and the lower priorities are evaluated normally.
- drop_pend must survive a D-mem wait. It is cleared only by P5 or by reset.
- A second redirect while drop_pend=1 leaves drop_pend=1; only one stale response is possible.
- stall_cnt_o+1 on every cycle where stall_o[0]=1, saturating at all-ones.
- Reset mid-DWAIT or with drop_pend=1 returns to RUN and clears all state next edge, with no residual flush.
- r0 never causes a load-use stall.

Test Plan:
- lw x5 in EX (ex_mem_re_i=1, ex_rd_i=5), ID uses r2=5 → one cycle stall_o=00011, flush_o=00100; next cycle with ex_mem_re_i=0 → stall_o=0, flush_o=0; stall_cnt_o=1.
- Same as above with ex_rd_i=0, id_r1_i=0, id_use_r1_i=1 → stall_o=0, flush_o=0.
- ex_taken_i=1 and a load-use both true in one cycle → flush_o=00110, stall_o=0, flush_cnt_o increments by 1.
- mem_re_i=1, dmem_ready_i=0 for 3 cycles with ex_taken_i=1 → stall_o=01111 and flush_o=10000 for 3 cycles; ready cycle → flush_o=00110 (redirect serviced), flush_cnt_o=1.
- imem_ready_i=0, ex_taken_i pulse, imem_ready_i=1 two cycles later → redirect cycle flush_o=00110 and drop_pend=1; ready cycle stall_o=00001, flush_o=00010, drop_pend=0.
- Assert rst during DWAIT → next edge st=RUN, counters=0, outputs 0 while rst is high.
